// File: rtl/imem_param_sync.sv
// Synchronous instruction memory: registered fetch port with stall hold, program-load
// write port, and a reset-triggered sweep that fills every word with NOP before use.
module imem_param_sync #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 256,
    parameter int              AW       = 32,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013,
    parameter int              IW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [AW-1:0]   fetch_addr,
    input  logic            fetch_stall,
    output logic [XLEN-1:0] instr_out,
    output logic            instr_valid,
    output logic            fault_mis,
    output logic            fault_range,
    input  logic            prog_we,
    input  logic [IW-1:0]   prog_idx,
    input  logic [XLEN-1:0] prog_data,
    output logic            ready
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_clr_ptr;
    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_instr;
    logic            r_valid;
    logic            r_fault_mis;
    logic            r_fault_range;
    logic            r_ready;

    logic            w_prog;
    logic            w_we;
    logic [IW-1:0]   w_widx;
    logic [XLEN-1:0] w_wdata;
    logic [IW-1:0]   w_fidx;
    logic            w_mis;
    logic            w_range;
    logic [XLEN-1:0] w_rd;

    assign w_prog  = (r_state == S_READY) && prog_we;
    assign w_we    = (r_state == S_CLEAR) || w_prog;
    assign w_widx  = (r_state == S_CLEAR) ? r_clr_ptr : prog_idx;
    assign w_wdata = (r_state == S_CLEAR) ? NOP_WORD  : prog_data;

    // Any address bit above the word index means the fetch is past the end of the array.
    assign w_fidx  = fetch_addr[IW+1:2];
    assign w_mis   = |fetch_addr[1:0];
    assign w_range = |fetch_addr[AW-1:IW+2];

    // A program write landing on the fetched word in the same cycle is forwarded.
    assign w_rd = (w_prog && (prog_idx == w_fidx)) ? prog_data : r_mem[w_fidx];

    // NOTE: the array has no reset branch; the CLEAR sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_mem[w_widx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_CLEAR;
            r_clr_ptr     <= '0;
            r_instr       <= NOP_WORD;
            r_valid       <= 1'b0;
            r_fault_mis   <= 1'b0;
            r_fault_range <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + IW'(1);
                    if (r_clr_ptr == IW'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    if (!fetch_stall) begin
                        if (fetch_req) begin
                            r_valid       <= 1'b1;
                            r_fault_mis   <= w_mis;
                            r_fault_range <= w_range;
                            r_instr       <= (w_mis || w_range) ? NOP_WORD : w_rd;
                        end else begin
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign fault_mis   = r_fault_mis;
    assign fault_range = r_fault_range;
    assign ready       = r_ready;

endmodule

// File: tb/tb_imem_param_sync.sv
// Bench for imem_param_sync: directed scenarios plus randomized traffic, all compared
// against a word-array reference model that applies the memory's rules each clock.
module tb_imem_param_sync;

    localparam int              XLEN  = 32;
    localparam int              DEPTH = 256;
    localparam int              AW    = 32;
    localparam int              IW    = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP   = 32'h0000_0013;

    logic            clk;
    logic            reset;
    logic            fetch_req;
    logic [AW-1:0]   fetch_addr;
    logic            fetch_stall;
    logic [XLEN-1:0] instr_out;
    logic            instr_valid;
    logic            fault_mis;
    logic            fault_range;
    logic            prog_we;
    logic [IW-1:0]   prog_idx;
    logic [XLEN-1:0] prog_data;
    logic            ready;

    imem_param_sync #(
        .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .fault_mis(fault_mis), .fault_range(fault_range),
        .prog_we(prog_we), .prog_idx(prog_idx), .prog_data(prog_data),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [XLEN-1:0] m_mem [DEPTH];
    logic            m_ready = 1'b0;
    int              m_cnt   = 0;
    logic [XLEN-1:0] m_instr = NOP;
    logic            m_valid = 1'b0;
    logic            m_fm    = 1'b0;
    logic            m_fr    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int unsigned widx;
        bit          mis;
        bit          rng;
        if (reset) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_instr = NOP;
            m_valid = 1'b0;
            m_fm    = 1'b0;
            m_fr    = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_mem[i]) m_mem[i] = NOP;
            end
        end else begin
            if (prog_we) m_mem[prog_idx] = prog_data;
            if (!fetch_stall) begin
                if (fetch_req) begin
                    widx    = fetch_addr / 4;
                    mis     = (fetch_addr % 4) != 0;
                    rng     = widx >= DEPTH;
                    m_valid = 1'b1;
                    m_fm    = mis;
                    m_fr    = rng;
                    m_instr = (mis || rng) ? NOP : m_mem[widx];
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("ready",       32'(ready),       32'(m_ready));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr_out",   instr_out,        m_instr);
        check("fault_mis",   32'(fault_mis),   32'(m_fm));
        check("fault_range", 32'(fault_range), 32'(m_fr));
    endtask

    // Inputs are applied 1 time unit after an edge and outputs sampled at the same point.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
        prog_we     = 1'b0;
        prog_idx    = '0;
        prog_data   = '0;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (!ready && n < DEPTH + 10) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // 1: single-cycle reset, sweep length, fetches of cleared words
        @(posedge clk);
        #1;
        step();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr_out, NOP);
        reset = 1'b0;
        count_clear("clear_len");
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        step();
        check("t1_addr0", instr_out, NOP);
        fetch_addr = 32'h3FC;
        step();
        check("t1_addr3fc", instr_out, NOP);
        check("t1_valid", 32'(instr_valid), 32'd1);

        // 2: program then fetch
        idle_inputs();
        prog_we   = 1'b1;
        prog_idx  = IW'(1);
        prog_data = 32'h0198_06B3;
        step();
        idle_inputs();
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        step();
        check("t2_instr", instr_out, 32'h0198_06B3);

        // 3: same-cycle write and fetch of one word
        prog_we    = 1'b1;
        prog_idx   = IW'(3);
        prog_data  = 32'h0094_8663;
        fetch_addr = 32'hC;
        step();
        check("t3_wfirst", instr_out, 32'h0094_8663);

        // 4: misaligned and out-of-range fetches
        idle_inputs();
        fetch_req  = 1'b1;
        fetch_addr = 32'h6;
        step();
        check("t4_mis", 32'(fault_mis), 32'd1);
        check("t4_mis_nop", instr_out, NOP);
        fetch_addr = 32'h400;
        step();
        check("t4_range", 32'(fault_range), 32'd1);
        check("t4_range_nop", instr_out, NOP);

        // 5: stall holds the previous result
        fetch_addr = 32'h4;
        step();
        fetch_stall = 1'b1;
        fetch_addr  = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_hold", instr_out, 32'h0198_06B3);
            check("t5_valid", 32'(instr_valid), 32'd1);
        end
        fetch_stall = 1'b0;
        fetch_req   = 1'b0;
        step();
        check("t5_drop", 32'(instr_valid), 32'd0);

        // 6: reset in the middle of the sweep restarts it
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_clear("t6_restart_len");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned kind;
            int unsigned idx;
            reset       = ($urandom_range(0, 599) == 0);
            fetch_req   = ($urandom_range(0, 3) != 0);
            fetch_stall = ($urandom_range(0, 4) == 0);
            kind        = $urandom_range(0, 5);
            idx         = $urandom_range(0, DEPTH - 1);
            if (kind <= 2)      fetch_addr = 32'(idx * 4);
            else if (kind == 3) fetch_addr = 32'(idx * 4 + $urandom_range(1, 3));
            else                fetch_addr = $urandom | 32'h0000_0400;
            prog_we   = ($urandom_range(0, 2) == 0);
            prog_idx  = ($urandom_range(0, 3) == 0) ? IW'(idx) : IW'($urandom_range(0, DEPTH - 1));
            prog_data = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
